// File: rtl/swerv_types.sv
// Shared types for the LSU trigger controller: tdata1 field positions, the
// stored tdata1 view and the CSR write FSM states.
package swerv_types;

  localparam int unsigned TD1_LOAD   = 0;
  localparam int unsigned TD1_STORE  = 1;
  localparam int unsigned TD1_M      = 6;
  localparam int unsigned TD1_MATCH  = 7;
  localparam int unsigned TD1_CHAIN  = 11;
  localparam int unsigned TD1_ACTION = 12;
  localparam int unsigned TD1_SELECT = 19;
  localparam int unsigned TD1_HIT    = 20;
  localparam int unsigned TD1_DMODE  = 27;

  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic store;
    logic load;
  } trig_tdata1_t;

  typedef enum logic [1:0] {IDLE, UPD, ARM} wr_state_e;

  function automatic logic [31:0] td1_pack(trig_tdata1_t t);
    logic [31:0] r;
    r             = '0;
    r[TD1_LOAD]   = t.load;
    r[TD1_STORE]  = t.store;
    r[TD1_M]      = t.m;
    r[TD1_MATCH]  = t.match;
    r[TD1_CHAIN]  = t.chain;
    r[TD1_ACTION] = t.action;
    r[TD1_SELECT] = t.select;
    r[TD1_HIT]    = t.hit;
    r[TD1_DMODE]  = t.dmode;
    return r;
  endfunction

  function automatic trig_tdata1_t td1_unpack(logic [31:0] d);
    trig_tdata1_t t;
    t.load   = d[TD1_LOAD];
    t.store  = d[TD1_STORE];
    t.m      = d[TD1_M];
    t.match  = d[TD1_MATCH];
    t.chain  = d[TD1_CHAIN];
    t.action = d[TD1_ACTION];
    t.select = d[TD1_SELECT];
    t.hit    = d[TD1_HIT];
    t.dmode  = d[TD1_DMODE];
    return t;
  endfunction

endpackage

// File: rtl/lsu_trigger_chain.sv
// Combinational match qualification, pairwise chaining and action priority
// for the LSU triggers; feeds the dc4 flops in lsu_trigger_ctl.
module lsu_trigger_chain #(
  parameter int NTRIG = 4
) (
  input  logic               lsu_valid_dc3,
  input  logic               flush_dc3,
  input  logic               dbg_mode,
  input  logic [NTRIG-1:0]   armed,
  input  logic [NTRIG-1:0]   lsu_match_dc3,
  input  logic [NTRIG/2-1:0] pair_chain,
  input  logic [NTRIG-1:0]   action,
  output logic [NTRIG-1:0]   hit,
  output logic               fire,
  output logic               act
);

  logic [NTRIG-1:0] q;

  assign q = {NTRIG{lsu_valid_dc3 & ~flush_dc3 & ~dbg_mode}} & armed & lsu_match_dc3;

  genvar gi;
  generate
    for (gi = 0; gi < NTRIG / 2; gi++) begin : g_pair
      logic both;
      assign both          = q[2*gi] & q[2*gi+1];
      // A chained pair fires only together; the odd member never fires alone.
      assign hit[2*gi]     = pair_chain[gi] ? both : q[2*gi];
      assign hit[2*gi+1]   = pair_chain[gi] ? both : q[2*gi+1];
    end
  endgenerate

  assign fire = |hit;

  always_comb begin
    act = 1'b0;
    for (int i = NTRIG - 1; i >= 0; i--) begin
      if (hit[i]) act = action[i];
    end
  end

endmodule

// File: rtl/lsu_trigger_ctl.sv
// LSU trigger configuration/action controller: tdata1/tdata2 state, CSR write
// FSM with per-trigger disarm, and registered dc4 fire. Chaining: LSU_TRIG_CHAIN_EN.
module lsu_trigger_ctl #(
  parameter int NTRIG = 4,
  parameter int TDW   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_wr_valid,
  output logic                  csr_wr_ready,
  input  logic [1:0]            csr_wr_idx,
  input  logic                  csr_wr_sel,
  input  logic [31:0]           csr_wr_data,
  input  logic                  dbg_mode,
  output logic [NTRIG-1:0]      trig_select,
  output logic [NTRIG-1:0]      trig_match,
  output logic [NTRIG-1:0]      trig_store,
  output logic [NTRIG-1:0]      trig_load,
  output logic [NTRIG*TDW-1:0]  trig_tdata2,
  output logic [NTRIG*32-1:0]   trig_tdata1_rd,
  input  logic                  lsu_valid_dc3,
  input  logic                  flush_dc3,
  input  logic [NTRIG-1:0]      lsu_match_dc3,
  output logic                  trig_fire_dc4,
  output logic                  trig_action_dc4,
  output logic [NTRIG-1:0]      trig_hit_dc4
);
  import swerv_types::*;

  wr_state_e        state_q, state_d;
  logic             ready_q, ready_d;
  logic [1:0]       idx_q, idx_d;
  trig_tdata1_t     tdata1_q [NTRIG];
  trig_tdata1_t     tdata1_d [NTRIG];
  logic [TDW-1:0]   tdata2_q [NTRIG];
  logic [TDW-1:0]   tdata2_d [NTRIG];
  logic             fire_q, fire_d, act_q, act_d;
  logic [NTRIG-1:0] hit_q, hit_d;

  logic [NTRIG-1:0]   armed, act_vec;
  logic [NTRIG/2-1:0] pair_chain;
  trig_tdata1_t       wr_td1;
  logic               wr_drop;
  logic               wr_data_unused;

  assign wr_data_unused = ^csr_wr_data;

  always_comb begin
    wr_td1        = td1_unpack(csr_wr_data);
    wr_td1.dmode  = csr_wr_data[TD1_DMODE] & dbg_mode;
    wr_td1.action = csr_wr_data[TD1_ACTION] & wr_td1.dmode;
`ifdef LSU_TRIG_CHAIN_EN
    wr_td1.chain  = csr_wr_data[TD1_CHAIN];
`else
    wr_td1.chain  = 1'b0;
`endif
  end

  // Debug-owned triggers are invisible to writes from outside debug mode.
  assign wr_drop = tdata1_q[csr_wr_idx].dmode & ~dbg_mode;

  genvar gi;
  generate
    for (gi = 0; gi < NTRIG; gi++) begin : g_trig
      assign armed[gi]        = !((state_q != IDLE) && (int'(idx_q) == gi));
      assign act_vec[gi]      = tdata1_q[gi].action;
      assign trig_select[gi]  = tdata1_q[gi].select;
      assign trig_match[gi]   = tdata1_q[gi].match;
      assign trig_store[gi]   = tdata1_q[gi].store & armed[gi];
      assign trig_load[gi]    = tdata1_q[gi].load & armed[gi];
      assign trig_tdata2[gi*TDW +: TDW]   = tdata2_q[gi];
      assign trig_tdata1_rd[gi*32 +: 32]  = td1_pack(tdata1_q[gi]);
    end
    for (gi = 0; gi < NTRIG / 2; gi++) begin : g_chain
      assign pair_chain[gi] = tdata1_q[2*gi].chain;
    end
  endgenerate

  lsu_trigger_chain #(.NTRIG(NTRIG)) u_chain (
    .lsu_valid_dc3 (lsu_valid_dc3),
    .flush_dc3     (flush_dc3),
    .dbg_mode      (dbg_mode),
    .armed         (armed),
    .lsu_match_dc3 (lsu_match_dc3),
    .pair_chain    (pair_chain),
    .action        (act_vec),
    .hit           (hit_d),
    .fire          (fire_d),
    .act           (act_d)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    idx_d    = idx_q;
    tdata1_d = tdata1_q;
    tdata2_d = tdata2_q;
    for (int i = 0; i < NTRIG; i++) begin
      if (hit_d[i]) tdata1_d[i].hit = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (csr_wr_valid && ready_q && !wr_drop) begin
          state_d = UPD;
          ready_d = 1'b0;
          idx_d   = csr_wr_idx;
          // A same-cycle hit set loses to the written value.
          if (csr_wr_sel) tdata2_d[csr_wr_idx] = TDW'(csr_wr_data);
          else            tdata1_d[csr_wr_idx] = wr_td1;
        end
      end
      UPD: state_d = ARM;
      ARM: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      idx_q    <= '0;
      tdata1_q <= '{default: '0};
      tdata2_q <= '{default: '0};
      fire_q   <= 1'b0;
      act_q    <= 1'b0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      idx_q    <= idx_d;
      tdata1_q <= tdata1_d;
      tdata2_q <= tdata2_d;
      fire_q   <= fire_d;
      act_q    <= act_d;
      hit_q    <= hit_d;
    end
  end

  assign csr_wr_ready    = ready_q;
  assign trig_fire_dc4   = fire_q;
  assign trig_action_dc4 = act_q;
  assign trig_hit_dc4    = hit_q;

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Directed bench for lsu_trigger_ctl: CSR write handshake, match vectors from a
// table, and hand-written multi-cycle corner sequences.
module tb_lsu_trigger_ctl;

  logic         clk;
  logic         rst;
  logic         csr_wr_valid;
  logic         csr_wr_ready;
  logic [1:0]   csr_wr_idx;
  logic         csr_wr_sel;
  logic [31:0]  csr_wr_data;
  logic         dbg_mode;
  logic [3:0]   trig_select, trig_match, trig_store, trig_load;
  logic [127:0] trig_tdata2;
  logic [127:0] trig_tdata1_rd;
  logic         lsu_valid_dc3, flush_dc3;
  logic [3:0]   lsu_match_dc3;
  logic         trig_fire_dc4, trig_action_dc4;
  logic [3:0]   trig_hit_dc4;

  int checks = 0;
  int errors = 0;

  lsu_trigger_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .csr_wr_valid   (csr_wr_valid),
    .csr_wr_ready   (csr_wr_ready),
    .csr_wr_idx     (csr_wr_idx),
    .csr_wr_sel     (csr_wr_sel),
    .csr_wr_data    (csr_wr_data),
    .dbg_mode       (dbg_mode),
    .trig_select    (trig_select),
    .trig_match     (trig_match),
    .trig_store     (trig_store),
    .trig_load      (trig_load),
    .trig_tdata2    (trig_tdata2),
    .trig_tdata1_rd (trig_tdata1_rd),
    .lsu_valid_dc3  (lsu_valid_dc3),
    .flush_dc3      (flush_dc3),
    .lsu_match_dc3  (lsu_match_dc3),
    .trig_fire_dc4  (trig_fire_dc4),
    .trig_action_dc4(trig_action_dc4),
    .trig_hit_dc4   (trig_hit_dc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       flush;
    logic       dbg;
    logic [3:0] match;
    logic       fire;
    logic [3:0] hit;
    logic       act;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_accept(input logic [1:0] idx, input logic sel, input logic [31:0] data);
    csr_wr_valid = 1'b1;
    csr_wr_idx   = idx;
    csr_wr_sel   = sel;
    csr_wr_data  = data;
    tick();
    csr_wr_valid = 1'b0;
  endtask

  task automatic wr_full(input logic [1:0] idx, input logic sel, input logic [31:0] data);
    wr_accept(idx, sel, data);
    chk("ready_upd", 64'(csr_wr_ready), 64'd0);
    tick();
    chk("ready_arm", 64'(csr_wr_ready), 64'd0);
    tick();
    chk("ready_idle", 64'(csr_wr_ready), 64'd1);
    $display("write idx=%0d sel=%0d data=%h", idx, sel, data);
  endtask

  initial begin
    rst = 1'b1;
    csr_wr_valid = 1'b0; csr_wr_idx = '0; csr_wr_sel = 1'b0; csr_wr_data = '0;
    dbg_mode = 1'b0; lsu_valid_dc3 = 1'b0; flush_dc3 = 1'b0; lsu_match_dc3 = '0;

    //            valid flush dbg   match    fire  hit      act
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1};
`ifdef LSU_TRIG_CHAIN_EN
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0};
`else
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0};
`endif
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 1'b1, 4'b1100, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0011, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, 4'b1110, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 64'(csr_wr_ready), 64'd1);
    chk("rst_fire", 64'(trig_fire_dc4), 64'd0);
    chk("rst_hit", 64'(trig_hit_dc4), 64'd0);
    chk("rst_store", 64'(trig_store), 64'd0);
    chk("rst_td1", trig_tdata1_rd[63:0], 64'd0);
    chk("rst_td2", trig_tdata2[63:0], 64'd0);

    // Trigger 0: store compare at 0x1000, store armed on the third cycle after accept.
    wr_full(2'd0, 1'b1, 32'h0000_1000);
    chk("td2_0", 64'(trig_tdata2[31:0]), 64'h1000);
    wr_accept(2'd0, 1'b0, 32'h0000_0002);
    chk("store0_upd", 64'(trig_store[0]), 64'd0);
    tick();
    chk("store0_arm", 64'(trig_store[0]), 64'd0);
    tick();
    chk("store0_idle", 64'(trig_store[0]), 64'd1);
    chk("td1_0", 64'(trig_tdata1_rd[31:0]), 64'h2);

    // Trigger 1 is debug-owned with enter-debug action.
    dbg_mode = 1'b1;
    wr_full(2'd1, 1'b0, 32'h0800_1002);
    dbg_mode = 1'b0;
    chk("td1_1", 64'(trig_tdata1_rd[63:32]), 64'h0800_1002);

    wr_full(2'd2, 1'b0, 32'h0000_0802);
`ifdef LSU_TRIG_CHAIN_EN
    chk("td1_2", 64'(trig_tdata1_rd[95:64]), 64'h0000_0802);
`else
    chk("td1_2", 64'(trig_tdata1_rd[95:64]), 64'h0000_0002);
`endif
    // dmode and action are forced off outside debug mode.
    wr_full(2'd3, 1'b0, 32'h0800_1002);
    chk("td1_3_forced", 64'(trig_tdata1_rd[127:96]), 64'h0000_0002);

    for (int k = 0; k < 11; k++) begin
      lsu_valid_dc3 = vecs[k].valid;
      flush_dc3     = vecs[k].flush;
      dbg_mode      = vecs[k].dbg;
      lsu_match_dc3 = vecs[k].match;
      tick();
      chk($sformatf("v%0d_fire", k), 64'(trig_fire_dc4), 64'(vecs[k].fire));
      chk($sformatf("v%0d_hit", k), 64'(trig_hit_dc4), 64'(vecs[k].hit));
      chk($sformatf("v%0d_act", k), 64'(trig_action_dc4), 64'(vecs[k].act));
      if (k == 0) chk("v0_sticky", 64'(trig_tdata1_rd[20]), 64'd1);
      $display("vec %0d match=%b fire=%b hit=%b act=%b", k, vecs[k].match,
               trig_fire_dc4, trig_hit_dc4, trig_action_dc4);
    end
    lsu_valid_dc3 = 1'b0; flush_dc3 = 1'b0; dbg_mode = 1'b0; lsu_match_dc3 = '0;
    tick();
    chk("fire_held_1cyc", 64'(trig_fire_dc4), 64'd0);
    chk("sticky_0", 64'(trig_tdata1_rd[31:0]), 64'h0010_0002);
    chk("sticky_1", 64'(trig_tdata1_rd[63:32]), 64'h0810_1002);
`ifdef LSU_TRIG_CHAIN_EN
    chk("sticky_2", 64'(trig_tdata1_rd[95:64]), 64'h0010_0802);
`else
    chk("sticky_2", 64'(trig_tdata1_rd[95:64]), 64'h0010_0002);
`endif
    chk("sticky_3", 64'(trig_tdata1_rd[127:96]), 64'h0010_0002);

    // Write to a debug-owned trigger from outside debug mode is dropped.
    wr_accept(2'd1, 1'b0, 32'h0000_0000);
    chk("drop_ready", 64'(csr_wr_ready), 64'd1);
    chk("drop_td1_1", 64'(trig_tdata1_rd[63:32]), 64'h0810_1002);
    $display("dropped write idx=1");

    // Match while trigger 0 is being updated must not fire.
    wr_accept(2'd0, 1'b1, 32'h0000_2000);
    lsu_valid_dc3 = 1'b1; lsu_match_dc3 = 4'b0001;
    chk("upd_disarm", 64'(trig_store[0]), 64'd0);
    chk("upd_other_armed", 64'(trig_store[2]), 64'd1);
    tick();
    chk("upd_nofire", 64'(trig_fire_dc4), 64'd0);
    tick();
    chk("arm_nofire", 64'(trig_fire_dc4), 64'd0);
    tick();
    chk("rearm_fire", 64'(trig_fire_dc4), 64'd1);
    chk("rearm_hit", 64'(trig_hit_dc4), 64'b0001);
    chk("td2_0_new", 64'(trig_tdata2[31:0]), 64'h2000);

    // Hit set and a hit-clearing write in the same cycle: write wins.
    wr_accept(2'd0, 1'b0, 32'h0000_0002);
    lsu_valid_dc3 = 1'b0; lsu_match_dc3 = '0;
    chk("clr_fire", 64'(trig_fire_dc4), 64'd1);
    chk("clr_hitbit", 64'(trig_tdata1_rd[20]), 64'd0);
    tick();
    tick();
    chk("clr_td1_0", 64'(trig_tdata1_rd[31:0]), 64'h2);
    $display("hit clear write idx=0");

    // Reset in the middle of a write.
    wr_accept(2'd2, 1'b1, 32'h0000_0055);
    rst = 1'b1; lsu_valid_dc3 = 1'b1; lsu_match_dc3 = 4'b0001;
    tick();
    rst = 1'b0; lsu_valid_dc3 = 1'b0; lsu_match_dc3 = '0;
    chk("mrst_ready", 64'(csr_wr_ready), 64'd1);
    chk("mrst_fire", 64'(trig_fire_dc4), 64'd0);
    chk("mrst_hit", 64'(trig_hit_dc4), 64'd0);
    chk("mrst_store", 64'(trig_store), 64'd0);
    chk("mrst_td2", trig_tdata2[127:64], 64'd0);
    chk("mrst_td1", trig_tdata1_rd[127:64], 64'd0);
    wr_accept(2'd0, 1'b1, 32'h0000_0001);
    chk("mrst_idle_accept", 64'(csr_wr_ready), 64'd0);
    $display("reset during write");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_trigger_ctl.md
Name: lsu_trigger_ctl

Overview:
Configuration and action controller for the four LSU data/address trigger comparators.
- Owns the tdata1/tdata2 trigger state and accepts CSR writes through a valid/ready handshake.
- Drives the per-trigger configuration into the dc3 comparators and takes back their raw per-trigger matches.
- Applies enable, chain and dmode rules, keeps sticky hit bits, and issues one registered trigger action in dc4 toward dec.

Parameters:
NTRIG, 4, number of triggers (must be even; chaining pairs 0/1, 2/3)
TDW, 32, tdata2 width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
csr_wr_valid  in  1  CSR write request
csr_wr_ready  out  1  controller can accept a write
csr_wr_idx  in  2  trigger index
csr_wr_sel  in  1  0 = tdata1, 1 = tdata2
csr_wr_data  in  32  write data
dbg_mode  in  1  core in debug mode
trig_select  out  NTRIG  per-trigger select (0 addr, 1 data)
trig_match  out  NTRIG  per-trigger match type (0 exact, 1 mask)
trig_store  out  NTRIG  store enable, gated by arm
trig_load  out  NTRIG  load enable, gated by arm
trig_tdata2  out  NTRIG*TDW  compare values, trigger i at [i*TDW +: TDW]
trig_tdata1_rd  out  NTRIG*32  tdata1 readback, including the hit bit
lsu_valid_dc3  in  1  non-DMA LSU op valid in dc3
flush_dc3  in  1  dc3 op killed
lsu_match_dc3  in  NTRIG  raw comparator matches
trig_fire_dc4  out  1  trigger action request
trig_action_dc4  out  1  0 = breakpoint exception, 1 = enter debug
trig_hit_dc4  out  NTRIG  triggers contributing to the fire

Behaviour:
tdata1 stored fields:
- bit0 load, bit1 store, bit6 m, bit7 match, bit11 chain, bit12 action, bit19 select, bit20 hit, bit27 dmode.
- All other bits read 0.

Reset (all values 0):
- All tdata1/tdata2 state, and therefore all trig_* outputs.
- trig_fire_dc4, trig_hit_dc4, trig_action_dc4.
- FSM returns to IDLE.
- csr_wr_ready = 1 in the cycle after reset deasserts.

Write FSM, states IDLE, UPD, ARM:
- IDLE: csr_wr_ready = 1. Accept when valid & ready and move to UPD. The register is written at that edge.
- Write to a trigger with dmode = 1 while dbg_mode = 0 is dropped: no register change, no state change.
- Writing dmode = 1 while dbg_mode = 0 forces dmode = 0.
- tdata1 write with action = 1 while dmode = 0 forces action = 0.
- UPD (1 cycle): csr_wr_ready = 0. Trigger csr_wr_idx has trig_load/trig_store masked to 0 (disarmed).
- ARM (1 cycle): csr_wr_ready = 0, still disarmed, so comparators settle on the new tdata2. Then return to IDLE.
- Write throughput: 1 per 3 cycles. Untouched triggers stay armed throughout.

Match qualification, combinational into dc4 flops:
- q[i] = lsu_valid_dc3 & ~flush_dc3 & ~dbg_mode & armed[i] & lsu_match_dc3[i].
- Chain (see Optional Feature): even trigger e with chain = 1 fires only if q[e] & q[e+1]. When paired, trigger e+1 alone never fires.
- Action is per trigger, from its own action bit. A fire uses the action of the lowest-index contributing trigger.
- trig_hit_dc4 = all contributing triggers. trig_fire_dc4 = |trig_hit_dc4.
- Latency: dc3 match to dc4 fire is exactly 1 cycle. Outputs are held for 1 cycle only.

Sticky hit bit:
- Set in the cycle trig_fire_dc4 is registered, for each hit trigger.
- A tdata1 write in the same cycle as a hit set: the write value wins.
- Cleared only by a tdata1 write with bit20 = 0.

flush_dc3 and an accepted write in the same cycle are independent.

Optional Feature:
LSU_TRIG_CHAIN_EN
- Defined: chain bit stored and honoured as above.
- Undefined: chain bit reads 0 and write data is ignored; every trigger qualifies independently.

Decomposition:
- swerv_types gets: trig_tdata1_t packed struct with the fields above; localparams for the bit positions; FSM state enum (IDLE, UPD, ARM).
- One sub-module, lsu_trigger_chain: pure combinational q/chain/priority resolve, instantiated once.

Test Plan:
- Reset then write tdata2[0]=0x1000, then tdata1[0]=0x0002 -> ready low 2 cycles per write. trig_store[0]=1 from the third cycle after the second accept.
- Store matches trigger 0 with lsu_valid_dc3=1, flush_dc3=0 -> next cycle trig_fire_dc4=1, trig_hit_dc4=4'b0001, trig_action_dc4=0, trig_tdata1_rd[20]=1.
- Chain on trigger 2; lsu_match_dc3=4'b0100 -> no fire. lsu_match_dc3=4'b1100 -> trig_hit_dc4=4'b1100, fire=1.
- Trigger 1 dmode=1, action=1, written in dbg_mode; then a write from dbg_mode=0 -> dropped, tdata1[1] unchanged. A match with dbg_mode=0 -> trig_action_dc4=1.
- Match with flush_dc3=1, or during UPD of the same trigger -> trig_fire_dc4=0. A simultaneous hit and hit-clear write -> hit bit reads 0.
- Assert rst while in UPD -> next cycle all outputs 0, FSM IDLE, csr_wr_ready=1.
